// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner: two-writer round-robin arbiter
// plus a sequencer that zeroes x1..x(XLEN-1) on command.
module regfile_write_arbiter #(
  parameter int N = 32,
  parameter int XLEN = 32,
  localparam int AW = $clog2(XLEN)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0_VALID,
  output logic          REQ0_READY,
  input  logic [AW-1:0] REQ0_ADDR,
  input  logic [N-1:0]  REQ0_DATA,
  input  logic          REQ1_VALID,
  output logic          REQ1_READY,
  input  logic [AW-1:0] REQ1_ADDR,
  input  logic [N-1:0]  REQ1_DATA,
  input  logic          CLR_START,
  output logic          CLR_BUSY,
  output logic          CLR_DONE,
  output logic          WE3,
  output logic [AW-1:0] A3,
  output logic [N-1:0]  WD3
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t      state;
  logic        ptr;
  logic [AW:0] cnt;
  logic        xfer0;
  logic        xfer1;
  logic        open;

  // ptr=0 favours port 0, ptr=1 favours port 1
  always_comb begin
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    open = (state == IDLE) && !CLR_START;
    if (open) begin
      if (REQ0_VALID && REQ1_VALID) begin
        REQ0_READY = !ptr;
        REQ1_READY = ptr;
      end else begin
        REQ0_READY = REQ0_VALID;
        REQ1_READY = REQ1_VALID;
      end
    end
    xfer0 = REQ0_VALID && REQ0_READY;
    xfer1 = REQ1_VALID && REQ1_READY;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      cnt      <= '0;
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      CLR_BUSY <= 1'b0;
      CLR_DONE <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          CLR_DONE <= 1'b0;
          if (CLR_START) begin
            state    <= CLEAR;
            cnt      <= (AW+1)'(1);
            CLR_BUSY <= 1'b1;
            WE3      <= 1'b0;
          end else if (xfer0) begin
            WE3 <= (REQ0_ADDR != '0);
            ptr <= 1'b1;
            if (REQ0_ADDR != '0) begin
              A3  <= REQ0_ADDR;
              WD3 <= REQ0_DATA;
            end
          end else if (xfer1) begin
            WE3 <= (REQ1_ADDR != '0);
            ptr <= 1'b0;
            if (REQ1_ADDR != '0) begin
              A3  <= REQ1_ADDR;
              WD3 <= REQ1_DATA;
            end
          end else begin
            WE3 <= 1'b0;
          end
        end
        CLEAR: begin
          WE3 <= 1'b1;
          A3  <= cnt[AW-1:0];
          WD3 <= '0;
          cnt <= cnt + 1'b1;
          if (cnt == (AW+1)'(XLEN-1))
            state <= DONE;
        end
        DONE: begin
          WE3      <= 1'b0;
          CLR_BUSY <= 1'b0;
          CLR_DONE <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed steps plus random
// traffic checked against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int N = 32;
  localparam int XLEN = 32;
  localparam int AW = $clog2(XLEN);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ0_VALID = 1'b0;
  logic          REQ0_READY;
  logic [AW-1:0] REQ0_ADDR = '0;
  logic [N-1:0]  REQ0_DATA = '0;
  logic          REQ1_VALID = 1'b0;
  logic          REQ1_READY;
  logic [AW-1:0] REQ1_ADDR = '0;
  logic [N-1:0]  REQ1_DATA = '0;
  logic          CLR_START = 1'b0;
  logic          CLR_BUSY;
  logic          CLR_DONE;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [N-1:0]  WD3;

  regfile_write_arbiter #(.N(N), .XLEN(XLEN)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA),
    .CLR_START(CLR_START), .CLR_BUSY(CLR_BUSY),
    .CLR_DONE(CLR_DONE), .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // reference model: last served port, pending clear addresses
  int            m_last;
  int            clr_q[$];
  bit            m_donew;
  logic          m_we;
  logic [AW-1:0] m_a;
  logic [N-1:0]  m_wd;
  logic          m_busy;
  logic          m_done;
  bit            g0, g1;
  logic          r0, r1;
  int            done_cnt;
  int            at;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    clr_q.delete();
    m_donew = 0;
    m_last = 1;
    m_we = 0;
    m_a = '0;
    m_wd = '0;
    m_busy = 0;
    m_done = 0;
  endfunction

  function automatic bit m_idle();
    return clr_q.size() == 0 && !m_donew;
  endfunction

  function automatic void m_ready(output bit e0, output bit e1);
    e0 = 0;
    e1 = 0;
    if (m_idle() && !CLR_START) begin
      if (REQ0_VALID && REQ1_VALID) begin
        e0 = (m_last == 1);
        e1 = (m_last == 0);
      end else begin
        e0 = REQ0_VALID;
        e1 = REQ1_VALID;
      end
    end
  endfunction

  task automatic chk_out();
    chk("we3", WE3, m_we);
    chk("a3", A3, m_a);
    chk("wd3", WD3, m_wd);
    chk("busy", CLR_BUSY, m_busy);
    chk("done", CLR_DONE, m_done);
  endtask

  task automatic cyc();
    bit e0, e1;
    logic [AW-1:0] ad;
    @(negedge CLK);
    m_ready(e0, e1);
    r0 = REQ0_READY;
    r1 = REQ1_READY;
    chk("rdy0", r0, e0);
    chk("rdy1", r1, e1);
    g0 = e0;
    g1 = e1;
    if (m_idle()) begin
      m_done = 0;
      if (CLR_START) begin
        for (int r = 1; r < XLEN; r++) clr_q.push_back(r);
        m_busy = 1;
        m_we = 0;
      end else if (e0 || e1) begin
        ad = e0 ? REQ0_ADDR : REQ1_ADDR;
        m_we = (ad != 0);
        if (ad != 0) begin
          m_a = ad;
          m_wd = e0 ? REQ0_DATA : REQ1_DATA;
        end
        m_last = e0 ? 0 : 1;
      end else begin
        m_we = 0;
      end
    end else if (clr_q.size() != 0) begin
      m_we = 1;
      m_a = AW'(clr_q.pop_front());
      m_wd = '0;
      if (clr_q.size() == 0) m_donew = 1;
    end else begin
      m_donew = 0;
      m_we = 0;
      m_busy = 0;
      m_done = 1;
    end
    @(posedge CLK);
    #1;
    chk_out();
    if (CLR_DONE) done_cnt++;
  endtask

  // called at posedge+1; returns at posedge+1 out of reset
  task automatic do_reset();
    bit e0, e1;
    #1 RST = 1'b0;
    m_reset();
    #1;
    chk_out();
    m_ready(e0, e1);
    chk("rst_rdy0", REQ0_READY, e0);
    chk("rst_rdy1", REQ1_READY, e1);
    @(posedge CLK);
    #1 RST = 1'b1;
    g0 = 0;
    g1 = 0;
  endtask

  task automatic rnd_req();
    if (!REQ0_VALID || g0) begin
      REQ0_VALID = ($urandom_range(0, 2) != 0);
      REQ0_ADDR = AW'($urandom_range(0, XLEN - 1));
      REQ0_DATA = $urandom;
    end
    if (!REQ1_VALID || g1) begin
      REQ1_VALID = ($urandom_range(0, 2) != 0);
      REQ1_ADDR = AW'($urandom_range(0, XLEN - 1));
      REQ1_DATA = $urandom;
    end
  endtask

  task automatic idle_req();
    REQ0_VALID = 0;
    REQ1_VALID = 0;
  endtask

  initial begin
    m_reset();
    g0 = 0;
    g1 = 0;
    done_cnt = 0;
    #1;
    chk_out();
    chk("init_rdy0", REQ0_READY, 0);
    @(posedge CLK);
    #1 RST = 1'b1;

    // single write on port 0
    REQ0_VALID = 1;
    REQ0_ADDR = 5;
    REQ0_DATA = 32'hDEADBEEF;
    cyc();
    chk("t2_rdy0", r0, 1);
    chk("t2_we", WE3, 1);
    chk("t2_a3", A3, 5);
    chk("t2_wd", WD3, 32'hDEADBEEF);
    idle_req();
    cyc();
    chk("t2_we_off", WE3, 0);
    chk("t2_a3_hold", A3, 5);

    // alternation with both held
    do_reset();
    REQ0_VALID = 1;
    REQ0_ADDR = 3;
    REQ0_DATA = 32'h33;
    REQ1_VALID = 1;
    REQ1_ADDR = 7;
    REQ1_DATA = 32'h77;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3_grant0", r0, (k % 2) == 0);
      chk("t3_a3", A3, (k % 2) == 0 ? 3 : 7);
    end

    // write to x0 is swallowed but advances pointer
    idle_req();
    REQ0_VALID = 1;
    REQ0_ADDR = 9;
    REQ0_DATA = 32'h55;
    cyc();
    idle_req();
    REQ1_VALID = 1;
    REQ1_ADDR = 0;
    REQ1_DATA = 32'h1;
    cyc();
    chk("t4_rdy1", r1, 1);
    chk("t4_we", WE3, 0);
    chk("t4_a3", A3, 9);
    REQ0_VALID = 1;
    REQ0_ADDR = 3;
    REQ1_ADDR = 7;
    cyc();
    chk("t4_ptr0", r0, 1);

    // clear sequence with traffic pending
    CLR_START = 1;
    cyc();
    chk("t5_rdy0", r0, 0);
    chk("t5_rdy1", r1, 0);
    CLR_START = 0;
    done_cnt = 0;
    at = 0;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k < XLEN) begin
        chk("t5_clr_a3", A3, k);
        chk("t5_clr_wd", WD3, 0);
      end
      if (CLR_DONE && at == 0) at = k;
    end
    chk("t5_done_at", at, 32);
    chk("t5_done_n", done_cnt, 1);
    cyc();
    chk("t5_ptr1", r1, 1);

    // reset in the middle of a clear
    idle_req();
    CLR_START = 1;
    cyc();
    CLR_START = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (m_we && m_a == 10) break;
    end
    chk("t6_at10", A3, 10);
    do_reset();
    chk("t6_busy", CLR_BUSY, 0);
    done_cnt = 0;
    for (int k = 0; k < 35; k++) cyc();
    chk("t6_nodone", done_cnt, 0);

    // random traffic, sporadic clears, one reset mid-traffic
    for (int k = 0; k < 600; k++) begin
      rnd_req();
      CLR_START = ($urandom_range(0, 79) == 0);
      cyc();
      CLR_START = 0;
      if (k == 300) begin
        REQ0_VALID = 1;
        REQ1_VALID = 1;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
